// File: rtl/e1_timing_pkg.sv
// Shared E1 timing constants and types for the frame-alignment path.
package e1_timing_pkg;

    localparam int unsigned DIV_DEFAULT   = 8;
    localparam int unsigned FRAME_IDX_W   = 4;
    localparam int unsigned FRAMES_PER_MF = 16;

    typedef logic [FRAME_IDX_W-1:0] frame_idx_t;

endpackage

// File: rtl/e1_frame_counter_clk_div.sv
// Integer clock divider producing the 4 Mbps bit clock, its rising-edge
// strobe and a same-edge falling-edge qualifier for the frame counter.
module clk_div_4mbps
    import e1_timing_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic saida,
    output logic tick,
    output logic fall_stb
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    // Unregistered so the frame index advances on the same edge saida falls.
    assign fall_stb = en && (div_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            saida   <= 1'b0;
            tick    <= 1'b0;
        end else if (en) begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
            tick    <= (div_cnt == HALF);
            if (div_cnt == HALF)
                saida <= 1'b1;
            else if (div_cnt == LAST)
                saida <= 1'b0;
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/e1_frame_counter.sv
// E1 frame timing: 4 Mbps bit clock, sample strobe, 4-bit frame index
// and multiframe-start flag.
module e1_frame_counter
    import e1_timing_pkg::*;
#(
    parameter int unsigned DIV   = DIV_DEFAULT,
    parameter int unsigned CNT_W = FRAME_IDX_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       saida,
    output logic       tick,
    output frame_idx_t dout4,
    output logic       mf_start
);

    if (DIV < 2 || (DIV % 2) != 0) begin : g_bad_div
        $error("e1_frame_counter: DIV must be even and >= 2");
    end
    if (CNT_W != FRAME_IDX_W) begin : g_bad_cnt_w
        $error("e1_frame_counter: CNT_W must be 4");
    end

    logic fall_stb;

    clk_div_4mbps #(.DIV(DIV)) u_div (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .saida    (saida),
        .tick     (tick),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clk) begin
        if (rst)
            dout4 <= '0;
        else if (fall_stb)
            dout4 <= dout4 + 1'b1;
    end

    // Product of two flops; dout4 never changes while tick is high.
    assign mf_start = tick & (dout4 == '0);

endmodule

// File: tb/tb_e1_frame_counter.sv
// Randomized check of e1_frame_counter (DIV=8 and DIV=2) against an
// arithmetic model driven by the count of enabled edges since reset.
module tb_e1_frame_counter;

    logic clk = 1'b0;
    logic rst;
    logic en;

    logic       saida8, tick8, mf8;
    logic [3:0] dout8;
    logic       saida2, tick2, mf2;
    logic [3:0] dout2;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model state: enabled edges since last reset, and whether the last edge counted.
    int unsigned n = 0;
    bit          last_en = 1'b0;

    always #5 clk = ~clk;

    e1_frame_counter #(.DIV(8)) dut8 (
        .clk(clk), .rst(rst), .en(en),
        .saida(saida8), .tick(tick8), .dout4(dout8), .mf_start(mf8)
    );

    e1_frame_counter #(.DIV(2)) dut2 (
        .clk(clk), .rst(rst), .en(en),
        .saida(saida2), .tick(tick2), .dout4(dout2), .mf_start(mf2)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t, n=%0d)", tag, got, exp, $time, n);
        end
    endtask

    task automatic check_div(input string tag, input int unsigned div,
                             input logic s, input logic t, input logic [3:0] d, input logic m);
        int unsigned ph;
        int unsigned frame;
        bit          exp_tick;
        ph       = n % div;
        frame    = (n / div) % 16;
        exp_tick = last_en && (ph == div / 2);
        check_eq({tag, ".saida"},    32'(s), (ph >= div / 2) ? 1 : 0);
        check_eq({tag, ".tick"},     32'(t), exp_tick ? 1 : 0);
        check_eq({tag, ".dout4"},    32'(d), frame);
        check_eq({tag, ".mf_start"}, 32'(m), (exp_tick && frame == 0) ? 1 : 0);
    endtask

    // One clock: inputs applied at negedge, model advanced at posedge, outputs checked at next negedge.
    task automatic step(input logic r, input logic e);
        rst = r;
        en  = e;
        @(posedge clk);
        if (r) begin
            n       = 0;
            last_en = 1'b0;
        end else if (e) begin
            n++;
            last_en = 1'b1;
        end else begin
            last_en = 1'b0;
        end
        @(negedge clk);
        check_div("div8", 8, saida8, tick8, dout8, mf8);
        check_div("div2", 2, saida2, tick2, dout2, mf2);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);

        // Continuous run past one full multiframe at DIV=8.
        for (int i = 0; i < 16 * 8 + 24; i++)
            step(1'b0, 1'b1);

        // Freeze for 5 cycles in the middle of a saida high phase.
        for (int i = 0; i < 8 && (n % 8) != 5; i++)
            step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b1);

        // Reset while dout4=9 and saida high, then observe restart.
        for (int i = 0; i < 200 && !(((n / 8) % 16) == 9 && (n % 8) >= 4); i++)
            step(1'b0, 1'b1);
        check_eq("pre_rst.dout4", 32'(dout8), 9);
        step(1'b1, 1'b1);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1);

        // Random enable with occasional resets.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(99) < 75) ? 1'b1 : 1'b0);

        // Long enabled stretch so the 15 -> 0 wrap and mf_start recur.
        for (int i = 0; i < 300; i++)
            step(1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
